// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter in front of a single FIFO write port.
// A grant lasts up to MAX_BURST transfers; i_full stalls without using slots.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_req_ready,
  input  logic                          i_full,
  output logic                          o_wen,
  output logic [FIFO_WIDTH-1:0]         o_wdata,
  output logic [NUM_REQ-1:0]            o_grant,
  output logic                          o_busy
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST) + 1;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   rr_ptr;

  logic [PW-1:0]      winner;
  logic [PW-1:0]      nxt_ptr;
  logic [NUM_REQ-1:0] win_oh;
  logic               found;
  int                 idx;
  logic               own_valid;
  logic               xfer;
  logic               last;

  // first valid requester at or after rr_ptr, wrapping
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_REQ;
      if (!found && i_req_valid[idx]) begin
        found  = 1'b1;
        winner = PW'(idx);
      end
    end
  end

  assign nxt_ptr   = PW'((int'(winner) + 1) % NUM_REQ);
  assign win_oh    = NUM_REQ'(1) << winner;
  assign own_valid = |(o_grant & i_req_valid);
  assign xfer      = (state == GRANT) && own_valid && !i_full;
  assign last      = (cnt == CW'(MAX_BURST - 1));

  assign o_busy      = (state == GRANT);
  assign o_wen       = xfer;
  assign o_req_ready = ((state == GRANT) && !i_full) ? o_grant : '0;

  // data of the current owner, zero when idle
  always_comb begin
    o_wdata = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if ((state == GRANT) && o_grant[k]) begin
        o_wdata = i_req_data[k*FIFO_WIDTH +: FIFO_WIDTH];
      end
    end
  end

  // arbitration FSM, owner, burst count and rotation pointer
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      o_grant <= '0;
      cnt     <= '0;
      rr_ptr  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (found) begin
            state   <= GRANT;
            o_grant <= win_oh;
            rr_ptr  <= nxt_ptr;
          end else begin
            o_grant <= '0;
          end
        end
        GRANT: begin
          if (!own_valid || (xfer && last)) begin
            state   <= IDLE;
            o_grant <= '0;
            cnt     <= '0;
          end else if (xfer) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          o_grant <= '0;
          cnt     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus random traffic,
// two instances (MAX_BURST 4 and 1) checked against an owner-level model.
module tb_fifo_wr_arbiter;

  localparam int N = 4;
  localparam int W = 4;

  logic           i_clk = 1'b0;
  logic           i_rst_n = 1'b0;
  logic [N-1:0]   valid = '0;
  logic [N*W-1:0] data = '0;
  logic           full = 1'b0;

  logic [N-1:0] rdy4, gnt4, rdy1, gnt1;
  logic         wen4, wen1, busy4, busy1;
  logic [W-1:0] wd4, wd1;

  always #5 i_clk = ~i_clk;

  fifo_wr_arbiter #(.NUM_REQ(N), .FIFO_WIDTH(W), .MAX_BURST(4)) dut4 (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req_valid(valid), .i_req_data(data),
    .o_req_ready(rdy4), .i_full(full),
    .o_wen(wen4), .o_wdata(wd4),
    .o_grant(gnt4), .o_busy(busy4)
  );

  fifo_wr_arbiter #(.NUM_REQ(N), .FIFO_WIDTH(W), .MAX_BURST(1)) dut1 (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req_valid(valid), .i_req_data(data),
    .o_req_ready(rdy1), .i_full(full),
    .o_wen(wen1), .o_wdata(wd1),
    .o_grant(gnt1), .o_busy(busy1)
  );

  int passed = 0;
  int total  = 0;

  // model: owner index (-1 = nobody), slots used, next start index
  int m_own[2];
  int m_used[2];
  int m_ptr[2];
  int mb[2];

  logic [N-1:0] gr_h[2][16];
  logic [N-1:0] rd_h[2][16];
  logic         wn_h[2][16];
  logic         by_h[2][16];
  int           hc;
  logic [W-1:0] wq[$];
  int           k;
  int           nw;
  logic [7:0]   exp28;
  logic [N-1:0] exp29[5];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_own[d]  = -1;
      m_used[d] = 0;
      m_ptr[d]  = 0;
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      if (m_own[d] < 0) begin
        for (int i = 0; i < N; i++) begin
          int w;
          w = (m_ptr[d] + i) % N;
          if (m_own[d] < 0 && valid[w]) begin
            m_own[d]  = w;
            m_used[d] = 0;
            m_ptr[d]  = (w + 1) % N;
          end
        end
      end else if (!valid[m_own[d]]) begin
        m_own[d]  = -1;
        m_used[d] = 0;
      end else if (!full) begin
        m_used[d]++;
        if (m_used[d] == mb[d]) begin
          m_own[d]  = -1;
          m_used[d] = 0;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      logic [N-1:0] eg, er, og, orr;
      logic         ew, eb, ow, ob;
      logic [W-1:0] ed, od;
      eb  = (m_own[d] >= 0);
      eg  = eb ? (N'(1) << m_own[d]) : '0;
      ew  = eb ? (valid[m_own[d]] && !full) : 1'b0;
      er  = (eb && !full) ? eg : '0;
      ed  = eb ? data[m_own[d]*W +: W] : '0;
      og  = (d == 1) ? gnt1 : gnt4;
      orr = (d == 1) ? rdy1 : rdy4;
      ow  = (d == 1) ? wen1 : wen4;
      ob  = (d == 1) ? busy1 : busy4;
      od  = (d == 1) ? wd1 : wd4;
      check($sformatf("d%0d_busy", d), ob, eb);
      check($sformatf("d%0d_grant", d), og, eg);
      check($sformatf("d%0d_wen", d), ow, ew);
      check($sformatf("d%0d_ready", d), orr, er);
      check($sformatf("d%0d_wdata", d), od, ed);
      check($sformatf("d%0d_ready_1hot", d), 32'($onehot0(orr)), 1);
    end
  endtask

  // one cycle: inputs already driven at the falling edge
  task automatic step();
    #1;
    check_all();
    if (hc < 16) begin
      gr_h[0][hc] = gnt4;  gr_h[1][hc] = gnt1;
      rd_h[0][hc] = rdy4;  rd_h[1][hc] = rdy1;
      wn_h[0][hc] = wen4;  wn_h[1][hc] = wen1;
      by_h[0][hc] = busy4; by_h[1][hc] = busy1;
    end
    hc++;
    if (wen4) wq.push_back(wd4);
    @(posedge i_clk);
    model_step();
    @(negedge i_clk);
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    valid   = '0;
    full    = 1'b0;
    data    = '0;
    model_reset();
    #1;
    check_all();
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    hc = 0;
    wq.delete();
  endtask

  initial begin
    mb[0] = 4;
    mb[1] = 1;
    model_reset();
    @(negedge i_clk);

    // single requester, 6 words, burst of 4 then re-grant
    do_reset();
    k = 0;
    for (int c = 0; c < 10; c++) begin
      valid = (k < 6) ? 4'b0010 : 4'b0000;
      data  = '0;
      data[W +: W] = 4'(k + 1);
      step();
      if (wn_h[0][c]) k++;
    end
    exp28 = 8'b1101_1110;
    check("r28_grant_c1", gr_h[0][1], 4'b0010);
    for (int c = 0; c < 8; c++)
      check($sformatf("r28_wen_c%0d", c), wn_h[0][c], exp28[c]);
    check("r28_idle_c5", by_h[0][5], 1'b0);
    check("r28_regrant_c6", gr_h[0][6], 4'b0010);
    check("r28_nwords", wq.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < wq.size())
        check($sformatf("r28_word%0d", i), wq[i], 4'(i + 1));

    // round robin, all valid, MAX_BURST=1 instance
    do_reset();
    for (int c = 0; c < 10; c++) begin
      valid = 4'hF;
      data  = 16'($urandom);
      step();
    end
    exp29 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    nw = 0;
    for (int i = 0; i < 5; i++)
      check($sformatf("r29_grant%0d", i), gr_h[1][2*i+1], exp29[i]);
    for (int c = 0; c < 10; c++) if (wn_h[1][c]) nw++;
    check("r29_nwrites", nw, 5);

    // full stall mid-burst at cnt=2
    do_reset();
    for (int c = 0; c < 10; c++) begin
      valid = (c < 8) ? 4'b0100 : 4'b0000;
      full  = (c >= 3 && c <= 5);
      data  = 16'($urandom);
      step();
    end
    full = 1'b0;
    for (int c = 3; c <= 5; c++) begin
      check($sformatf("r30_wen_c%0d", c), wn_h[0][c], 1'b0);
      check($sformatf("r30_rdy_c%0d", c), rd_h[0][c], 4'b0000);
      check($sformatf("r30_gnt_c%0d", c), gr_h[0][c], 4'b0100);
    end
    check("r30_wen_c6", wn_h[0][6], 1'b1);
    check("r30_wen_c7", wn_h[0][7], 1'b1);
    check("r30_idle_c8", by_h[0][8], 1'b0);
    check("r30_nwords", wq.size(), 4);

    // early release, pending req3 next
    do_reset();
    for (int c = 0; c < 8; c++) begin
      valid = (c < 2) ? 4'b1001 : ((c < 6) ? 4'b1000 : 4'b0000);
      data  = 16'($urandom);
      step();
    end
    check("r31_gnt_c1", gr_h[0][1], 4'b0001);
    check("r31_wen_c1", wn_h[0][1], 1'b1);
    check("r31_wen_c2", wn_h[0][2], 1'b0);
    check("r31_idle_c3", by_h[0][3], 1'b0);
    check("r31_gnt_c4", gr_h[0][4], 4'b1000);

    // reset during the second transfer
    do_reset();
    valid = 4'b1100;
    data  = 16'h5A3C;
    step();
    step();
    #1;
    check("r32_wen_before", wen4, 1'b1);
    i_rst_n = 1'b0;
    model_reset();
    #1;
    check("r32_wen_rst", wen4, 1'b0);
    check("r32_gnt_rst", gnt4, 4'b0000);
    check("r32_wdata_rst", wd4, 4'h0);
    check_all();
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    hc = 0;
    step();
    step();
    check("r32_regrant", gr_h[0][1], 4'b0100);

    // pointer wrap: ptr=3 with req0 and req3 valid
    do_reset();
    for (int c = 0; c < 10; c++) begin
      valid = (c == 0) ? 4'b0100 : 4'b1001;
      data  = 16'($urandom);
      step();
    end
    check("r33_gnt_c3", gr_h[0][3], 4'b1000);
    check("r33_gnt_c8", gr_h[0][8], 4'b0001);

    // random traffic with occasional resets
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      valid = 4'($urandom);
      full  = ($urandom_range(0, 3) == 0);
      data  = 16'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of write requesters, 2..8.
REQ-002 Parameter FIFO_WIDTH, default 4: data word width, equal to the downstream FIFO data width.
REQ-003 Parameter MAX_BURST, default 4: maximum consecutive transfers per grant, 1..16.
REQ-004 The block SHALL have one clock and an asynchronous active-low reset: i_clk (input, 1) is the write-domain clock and i_rst_n (input, 1) is the asynchronous active-low reset.
REQ-005 i_req_valid, input, NUM_REQ: per-requester data-valid.
REQ-006 i_req_data, input, NUM_REQ*FIFO_WIDTH: requester k data in bits [k*FIFO_WIDTH +: FIFO_WIDTH].
REQ-007 o_req_ready, output, NUM_REQ: per-requester accept strobe.
REQ-008 i_full, input, 1: FIFO full flag, in the i_clk domain.
REQ-009 o_wen, output, 1: FIFO write enable.
REQ-010 o_wdata, output, FIFO_WIDTH: FIFO write data.
REQ-011 o_grant, output, NUM_REQ: registered one-hot current owner.
REQ-012 o_busy, output, 1: high while in GRANT.

Function
REQ-013 FSM has two states, IDLE and GRANT; the state, o_grant, the burst counter cnt (width clog2(MAX_BURST)+1) and the round-robin pointer rr_ptr (width clog2(NUM_REQ)) are registers.
REQ-014 IDLE, i_req_valid != 0: select winner = first k with i_req_valid[k]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ; next cycle state=GRANT, o_grant=onehot(winner), cnt=0, rr_ptr=(winner+1) mod NUM_REQ.
REQ-015 IDLE, i_req_valid == 0: remain IDLE; o_grant=0.
REQ-016 Grant-to-first-write latency: exactly 1 cycle after the IDLE cycle in which valid was seen.
REQ-017 GRANT: o_req_ready = o_grant & {NUM_REQ{~i_full}}; o_wen = |(o_grant & i_req_valid) & ~i_full; o_wdata = data of the granted requester (combinational mux), else 0.
REQ-018 A transfer occurs on a cycle with o_wen=1; a transfer SHALL increment cnt.
REQ-019 Release from GRANT to IDLE: (transfer and cnt==MAX_BURST-1), or granted requester's valid=0; on release the next cycle has o_grant=0 and cnt=0.
REQ-020 i_full=1 in GRANT: o_wen=0, o_req_ready=0; cnt and grant hold; no burst slot consumed.
REQ-021 Valid drops while i_full=1: release per REQ-019, with no write.
REQ-022 Non-granted requesters always see o_req_ready=0; at most one o_req_ready bit and one write per cycle.
REQ-023 No IDLE write: o_wen=0, o_req_ready=0, o_wdata=0 whenever state=IDLE.
REQ-024 Fairness: a continuously-valid requester SHALL be granted within NUM_REQ-1 intervening grants.
REQ-025 rr_ptr wraps from NUM_REQ-1 to 0; with MAX_BURST=1 every grant SHALL carry at most one transfer.

Reset
REQ-026 i_rst_n low SHALL immediately and asynchronously force: state=IDLE, o_grant=0, cnt=0, rr_ptr=0, o_busy=0, o_wen=0, o_req_ready=0, o_wdata=0.
REQ-027 Reset asserted mid-burst SHALL abort the burst with no further write; after deassertion arbitration restarts from requester 0 at the first i_clk edge.

Verification
REQ-028 Single requester: NUM_REQ=4, MAX_BURST=4, req1 valid held for 6 words D0..D5, i_full=0 -> grant at cycle 1; D0..D3 written in cycles 1..4; IDLE at cycle 5; re-grant at cycle 6; D4, D5 written in cycles 6..7.
REQ-029 Round-robin: all 4 valid continuously, MAX_BURST=1 -> grant order 0,1,2,3,0; one write every 2 cycles.
REQ-030 Full stall: granted req2 mid-burst with cnt=2, i_full high for 3 cycles -> o_wen=0 and o_req_ready=0 for those 3 cycles, cnt stays 2, grant held; the remaining 2 words are written after i_full falls.
REQ-031 Early release: req0 granted, valid drops after 1 word -> IDLE the next cycle; pending req3 granted 1 cycle later.
REQ-032 Reset mid-burst: i_rst_n low during the 2nd transfer -> o_wen=0 and o_grant=0 in the same cycle; after release with req2 and req3 valid, req2 is granted first.
REQ-033 Wrap: rr_ptr=3, req0 and req3 valid -> req3 granted, then req0.
